// File: rtl/mips_datapath_alu_muldiv_if.sv
// Control bundle shared by execute-stage blocks: the single clock
// (rising edge active) and the synchronous active-low reset.
//   clock : system clock
//   reset : synchronous reset, 0 = reset asserted
interface mips_datapath_alu_muldiv_if;
  logic clock;
  logic reset;

  modport sink   (input  clock, input  reset);
  modport source (output clock, output reset);
endinterface

// File: rtl/mips_datapath_alu_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Sits beside the execute-stage ALU and takes the same register operands.
// Multi-cycle ops (MULT/MULTU/DIV/DIVU/MADD/MADDU) run one radix-2 step per
// cycle on magnitudes; sign correction and the HI/LO commit happen in a final
// FIX cycle. MTHI/MTLO write HI/LO directly at the accepting edge.
//
// Ports:
//   ctrl    : clock / synchronous active-low reset bundle
//   start   : request, sampled only while busy=0
//   func    : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
//   data1   : multiplicand / dividend / move source
//   data2   : multiplier / divisor
//   abort   : cancels an in-flight operation (ignored while idle)
//   busy    : operation in flight (registered)
//   done    : one-cycle pulse when a multi-cycle result is committed
//   hi, lo  : HI/LO registers
//   divZero : last accepted divide had a zero divisor (sticky until next start)
module mips_datapath_alu_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  mips_datapath_alu_muldiv_if.sink   ctrl,
  input  logic                       start,
  input  logic [2:0]                 func,
  input  logic [DATA_W-1:0]          data1,
  input  logic [DATA_W-1:0]          data2,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_W-1:0]          hi,
  output logic [DATA_W-1:0]          lo,
  output logic                       divZero
);

  localparam int PW = 2 * DATA_W;

  localparam logic [2:0] F_MULT  = 3'd0;
  localparam logic [2:0] F_MULTU = 3'd1;
  localparam logic [2:0] F_DIV   = 3'd2;
  localparam logic [2:0] F_DIVU  = 3'd3;
  localparam logic [2:0] F_MTHI  = 3'd4;
  localparam logic [2:0] F_MTLO  = 3'd5;
  localparam logic [2:0] F_MADD  = 3'd6;
  localparam logic [2:0] F_MADDU = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Magnitude of a two's-complement operand; MIN maps to itself, which is
  // the correct unsigned magnitude 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] abs_w(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // Control state (reset)
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;

  // Datapath state (no reset; only meaningful while busy)
  logic [2:0]         func_q, func_d;
  logic [DATA_W-1:0]  opnd_q, opnd_d;     // |multiplicand| or |divisor|
  logic [PW-1:0]      acc_q, acc_d;       // {partial, multiplier} or {remainder, quotient}
  logic               neg_lo_q, neg_lo_d; // product / quotient sign
  logic               neg_hi_q, neg_hi_d; // remainder sign (dividend's)
  logic               dz_pend_q, dz_pend_d;

  logic               is_signed_in;
  logic               is_div_q;

  // Shift-add multiply step: the carry out of the upper-half add is kept
  // and shifted in as the new MSB.
  logic [DATA_W:0]    mul_sum;
  logic [PW-1:0]      mul_next;
  // Restoring divide step on {remainder, next dividend bit}.
  logic [DATA_W:0]    div_tmp;
  logic [DATA_W:0]    div_diff;
  logic               div_ge;
  logic [PW-1:0]      div_next;

  logic [PW-1:0]      prod_fix;
  logic [PW-1:0]      madd_sum;
  logic [DATA_W-1:0]  quo_fix;
  logic [DATA_W-1:0]  rem_fix;

  assign is_signed_in = (func == F_MULT) || (func == F_DIV) || (func == F_MADD);
  assign is_div_q     = (func_q == F_DIV) || (func_q == F_DIVU);

  assign mul_sum  = {1'b0, acc_q[PW-1:DATA_W]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[DATA_W-1:1]} : {1'b0, acc_q[PW-1:1]};

  assign div_tmp  = acc_q[PW-1:DATA_W-1];
  assign div_diff = div_tmp - {1'b0, opnd_q};
  assign div_ge   = (div_tmp >= {1'b0, opnd_q});
  assign div_next = div_ge ? {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1}
                           : {div_tmp[DATA_W-1:0],  acc_q[DATA_W-2:0], 1'b0};

  assign prod_fix = neg_p(acc_q, neg_lo_q);
  assign madd_sum = {hi_q, lo_q} + prod_fix;
  assign quo_fix  = neg_w(acc_q[DATA_W-1:0], neg_lo_q);
  // With a zero divisor the restoring steps shift the whole dividend
  // magnitude into the remainder, so re-signing it yields data1 unchanged.
  assign rem_fix  = neg_w(acc_q[PW-1:DATA_W], neg_hi_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    func_d     = func_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dz_pend_d  = dz_pend_q;

    case (state_q)
      IDLE: begin
        // start has priority over abort here: abort only targets older work.
        if (start) begin
          if (func == F_MTHI) begin
            hi_d = data1;
          end else if (func == F_MTLO) begin
            lo_d = data1;
          end else begin
            func_d     = func;
            neg_lo_d   = is_signed_in & (data1[DATA_W-1] ^ data2[DATA_W-1]);
            neg_hi_d   = is_signed_in & data1[DATA_W-1];
            dz_pend_d  = ((func == F_DIV) || (func == F_DIVU)) && (data2 == '0);
            div_zero_d = 1'b0;
            cnt_d      = CNT_W'(DATA_W);
            busy_d     = 1'b1;
            state_d    = CALC;
            if ((func == F_DIV) || (func == F_DIVU)) begin
              opnd_d = is_signed_in ? abs_w(data2) : data2;
              acc_d  = {{DATA_W{1'b0}}, (is_signed_in ? abs_w(data1) : data1)};
            end else begin
              opnd_d = is_signed_in ? abs_w(data1) : data1;
              acc_d  = {{DATA_W{1'b0}}, (is_signed_in ? abs_w(data2) : data2)};
            end
          end
        end
      end

      CALC: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!abort) begin
          done_d = 1'b1;
          case (func_q)
            F_MULT, F_MULTU: {hi_d, lo_d} = prod_fix;
            F_MADD, F_MADDU: {hi_d, lo_d} = madd_sum;
            default: begin
              lo_d       = dz_pend_q ? {DATA_W{1'b1}} : quo_fix;
              hi_d       = rem_fix;
              div_zero_d = dz_pend_q;
            end
          endcase
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Control and architectural registers
  always_ff @(posedge ctrl.clock) begin
    if (!ctrl.reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // Iteration datapath
  always_ff @(posedge ctrl.clock) begin
    func_q    <= func_d;
    opnd_q    <= opnd_d;
    acc_q     <= acc_d;
    neg_lo_q  <= neg_lo_d;
    neg_hi_q  <= neg_hi_d;
    dz_pend_q <= dz_pend_d;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divZero = div_zero_q;

endmodule

// File: tb/tb_mips_datapath_alu_muldiv.sv
// Bench for mips_datapath_alu_muldiv: directed scenarios at DATA_W=32, then
// randomized operations at DATA_W=8 and DATA_W=16 against an arithmetic
// reference model of HI/LO/divZero.
module tb_mips_datapath_alu_muldiv;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_datapath_alu_muldiv_if ctrl_bus();
  assign ctrl_bus.clock = clk;
  assign ctrl_bus.reset = rst_n;

  logic        start, abort;
  logic [2:0]  func;
  logic [31:0] d1, d2;
  int          sel;
  int          w;

  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;
  logic        busy16, done16, dz16;
  logic [15:0] hi16, lo16;

  logic        cur_busy, cur_done, cur_dz;
  logic [31:0] cur_hi, cur_lo;

  mips_datapath_alu_muldiv #(.DATA_W(32)) dut32 (
    .ctrl(ctrl_bus), .start(start && sel == 0), .func(func), .data1(d1), .data2(d2),
    .abort(abort && sel == 0), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32),
    .divZero(dz32));

  mips_datapath_alu_muldiv #(.DATA_W(8)) dut8 (
    .ctrl(ctrl_bus), .start(start && sel == 1), .func(func), .data1(d1[7:0]), .data2(d2[7:0]),
    .abort(abort && sel == 1), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
    .divZero(dz8));

  mips_datapath_alu_muldiv #(.DATA_W(16)) dut16 (
    .ctrl(ctrl_bus), .start(start && sel == 2), .func(func), .data1(d1[15:0]), .data2(d2[15:0]),
    .abort(abort && sel == 2), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16),
    .divZero(dz16));

  always_comb begin
    cur_busy = busy32; cur_done = done32; cur_dz = dz32; cur_hi = hi32; cur_lo = lo32;
    if (sel == 1) begin
      cur_busy = busy8; cur_done = done8; cur_dz = dz8;
      cur_hi = {24'd0, hi8}; cur_lo = {24'd0, lo8};
    end else if (sel == 2) begin
      cur_busy = busy16; cur_done = done16; cur_dz = dz16;
      cur_hi = {16'd0, hi16}; cur_lo = {16'd0, lo16};
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference architectural state
  logic [31:0] m_hi, m_lo;
  logic        m_dz;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: applies one completed operation at width w using
  // native signed/unsigned arithmetic.
  function automatic void model_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ua, ub, res, hilo;
    longint      sa, sb, minv;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = ua[w-1] ? ($signed(ua) - $signed(64'd1 << w)) : $signed(ua);
    sb   = ub[w-1] ? ($signed(ub) - $signed(64'd1 << w)) : $signed(ub);
    minv = -(longint'(1) << (w - 1));
    hilo = ({32'd0, m_hi} << w) | {32'd0, m_lo};
    res  = '0;
    case (f)
      3'd4: m_hi = 32'(ua);
      3'd5: m_lo = 32'(ua);
      3'd2, 3'd3: begin
        m_dz = 1'b0;
        if (ub == 64'd0) begin
          m_lo = 32'(mask);
          m_hi = 32'(ua);
          m_dz = 1'b1;
        end else if (f == 3'd2) begin
          if (sa == minv && sb == -1) begin
            m_lo = 32'(ua);
            m_hi = 32'd0;
          end else begin
            m_lo = 32'(64'(sa / sb) & mask);
            m_hi = 32'(64'(sa % sb) & mask);
          end
        end else begin
          m_lo = 32'(ua / ub);
          m_hi = 32'(ua % ub);
        end
      end
      default: begin
        case (f)
          3'd0:    res = 64'(sa * sb);
          3'd1:    res = ua * ub;
          3'd6:    res = hilo + 64'(sa * sb);
          default: res = hilo + ua * ub;
        endcase
        m_lo = 32'(res & mask);
        m_hi = 32'((res >> w) & mask);
        m_dz = 1'b0;
      end
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    check("reset_hi", cur_hi, 0);
    check("reset_lo", cur_lo, 0);
    check("reset_busy", cur_busy, 0);
    check("reset_done", cur_done, 0);
    check("reset_divzero", cur_dz, 0);
  endtask

  // Issues one operation from a posedge+1 context and follows it to
  // completion, abort (sampled at edge abort_at) or reset (edge rst_at).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int abort_at, input int rst_at);
    logic [31:0] old_hi, old_lo;
    bit          bad;
    old_hi = m_hi;
    old_lo = m_lo;
    start = 1'b1; func = f; d1 = a; d2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (f == 3'd4 || f == 3'd5) begin
      model_op(f, a, b);
      check("move_busy", cur_busy, 0);
      check("move_done", cur_done, 0);
      check("move_hi", cur_hi, m_hi);
      check("move_lo", cur_lo, m_lo);
      return;
    end
    bad = (cur_busy !== 1'b1) || (cur_done !== 1'b0) || (cur_dz !== 1'b0);
    for (int k = 1; k <= w + 1; k++) begin
      if (k == abort_at) abort = 1'b1;
      if (k == rst_at) rst_n = 1'b0;
      @(posedge clk);
      #1;
      abort = 1'b0;
      rst_n = 1'b1;
      if (k == abort_at) begin
        m_dz = 1'b0;
        check("busy_before_abort", bad, 0);
        check("abort_busy", cur_busy, 0);
        check("abort_done", cur_done, 0);
        check("abort_hi", cur_hi, old_hi);
        check("abort_lo", cur_lo, old_lo);
        check("abort_divzero", cur_dz, 0);
        return;
      end
      if (k == rst_at) begin
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        check("midop_reset_hi", cur_hi, 0);
        check("midop_reset_lo", cur_lo, 0);
        check("midop_reset_busy", cur_busy, 0);
        check("midop_reset_done", cur_done, 0);
        check("midop_reset_divzero", cur_dz, 0);
        return;
      end
      if (k <= w) begin
        if ((cur_busy !== 1'b1) || (cur_done !== 1'b0) || (cur_hi !== old_hi) || (cur_lo !== old_lo))
          bad = 1'b1;
      end
    end
    model_op(f, a, b);
    check("busy_window", bad, 0);
    check("op_done", cur_done, 1);
    check("op_busy", cur_busy, 0);
    check("op_hi", cur_hi, m_hi);
    check("op_lo", cur_lo, m_lo);
    check("op_divzero", cur_dz, m_dz);
  endtask

  task automatic random_phase(input int sel_v, input int wv);
    logic [2:0]  f;
    logic [31:0] a, b;
    int          pick, ab, rs;
    sel = sel_v;
    w   = wv;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      f    = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      pick = $urandom_range(0, 15);
      if (pick == 0) b = 32'd0;
      if (pick == 1) begin a = 32'd1 << (w - 1); b = 32'hFFFF_FFFF; end
      if (pick == 2) a = 32'd1 << (w - 1);
      ab = 0;
      if (f != 3'd4 && f != 3'd5 && $urandom_range(0, 19) == 0) ab = $urandom_range(1, w + 1);
      rs = 0;
      if (i == 500) begin
        f  = 3'd1;
        ab = 0;
        rs = $urandom_range(2, w - 1);
      end
      run_op(f, a, b, ab, rs);
    end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; func = 3'd0; d1 = '0; d2 = '0;
    rst_n = 1'b0; sel = 0; w = 32;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(posedge clk);
    #1;

    // Directed scenarios at DATA_W = 32
    do_reset();
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("multu_max_hi", cur_hi, 32'hFFFF_FFFE);
    check("multu_max_lo", cur_lo, 32'h0000_0001);
    @(posedge clk);
    #1;
    check("done_one_cycle", cur_done, 0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
    check("mult_neg_hi", cur_hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", cur_lo, 32'hFFFF_FFEB);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("div_neg_lo", cur_lo, 32'hFFFF_FFFD);
    check("div_neg_hi", cur_hi, 32'hFFFF_FFFF);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("div_min_lo", cur_lo, 32'h8000_0000);
    check("div_min_hi", cur_hi, 32'h0000_0000);
    check("div_min_flag", cur_dz, 0);

    run_op(3'd3, 32'h0000_1234, 32'd0, 0, 0);
    check("divz_lo", cur_lo, 32'hFFFF_FFFF);
    check("divz_hi", cur_hi, 32'h0000_1234);
    check("divz_flag", cur_dz, 1);
    run_op(3'd1, 32'd2, 32'd3, 0, 0);
    check("divz_cleared", cur_dz, 0);

    run_op(3'd4, 32'd0, 32'd0, 0, 0);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd0, 0, 0);
    run_op(3'd7, 32'd1, 32'd1, 0, 0);
    check("maddu_hi", cur_hi, 32'd1);
    check("maddu_lo", cur_lo, 32'd0);
    run_op(3'd6, 32'hFFFF_FFFF, 32'd1, 0, 0);
    check("madd_lo", cur_lo, 32'hFFFF_FFFF);

    run_op(3'd3, 32'd1000, 32'd7, 10, 0);

    // Start held high through a busy period: second operands must wait.
    start = 1'b1; func = 3'd1; d1 = 32'd6; d2 = 32'd7;
    @(posedge clk);
    #1;
    d1 = 32'd2; d2 = 32'd3;
    repeat (33) @(posedge clk);
    #1;
    model_op(3'd1, 32'd6, 32'd7);
    check("held_first_done", cur_done, 1);
    check("held_first_lo", cur_lo, m_lo);
    check("held_first_busy", cur_busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("held_second_busy", cur_busy, 1);
    repeat (33) @(posedge clk);
    #1;
    model_op(3'd1, 32'd2, 32'd3);
    check("held_second_done", cur_done, 1);
    check("held_second_lo", cur_lo, m_lo);
    check("held_second_hi", cur_hi, m_hi);

    // Randomized width sweep
    random_phase(1, 8);
    random_phase(2, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
